// File: rtl/espi_frame_ctrl.sv
// eSPI frame sequencer: chip-select setup/hold timing and per-character go/done handshake
// in front of spi_master_trx_char. Optional RX discard of leading characters via ESPI_RX_SKIP_EN.
module espi_frame_ctrl #(
    parameter int CHAR_NBITS = 32,
    parameter int NUM_CS     = 4,
    parameter int LEN_W      = 16
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESET,
    input  logic                  S_ENABLE,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_CS,
    input  logic [LEN_W-1:0]      CMD_LEN,
    input  logic [LEN_W-1:0]      CMD_SKIP,
    input  logic [3:0]            CSBEF,
    input  logic [3:0]            CSAFT,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    input  logic [CHAR_NBITS-1:0] TX_DATA,
    output logic                  RX_VALID,
    input  logic                  RX_READY,
    output logic [CHAR_NBITS-1:0] RX_DATA,
    output logic                  CHAR_GO,
    input  logic                  CHAR_DONE,
    output logic [CHAR_NBITS-1:0] CHAR_WDATA,
    input  logic [CHAR_NBITS-1:0] CHAR_RDATA,
    output logic [NUM_CS-1:0]     SPI_CS_N,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic                  CMD_ERR
);
    typedef enum logic [2:0] {IDLE, SETUP, FETCH, GO, WAIT, STORE, HOLD} state_t;

    state_t           state;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] skip_q;
    logic [3:0]       dly;
    logic [3:0]       csaft_q;
    logic [NUM_CS-1:0] cs_sel;
    logic             cmd_acc, tx_acc, discard, store_done;

    assign CMD_READY  = (state == IDLE) && S_ENABLE;
    assign TX_READY   = (state == FETCH) && S_ENABLE;
    assign CHAR_GO    = (state == GO);
    assign BUSY       = (state != IDLE);
    assign discard    = (skip_q != '0);
    assign RX_VALID   = (state == STORE) && !discard;
    assign cmd_acc    = CMD_VALID && CMD_READY;
    assign tx_acc     = TX_VALID && TX_READY;
    assign store_done = (state == STORE) && (discard || RX_READY);

    // An index beyond NUM_CS selects no line; the frame still runs.
    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (CMD_CS == 2'(i)) cs_sel[i] = 1'b0;
    end

`ifdef ESPI_RX_SKIP_EN
    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET)
            skip_q <= '0;
        else if (cmd_acc)
            skip_q <= CMD_SKIP;
        else if (state == STORE && discard)
            skip_q <= skip_q - 1'b1;
    end
`else
    logic unused_skip;
    assign unused_skip = ^CMD_SKIP;
    assign skip_q      = '0;
`endif

    // SETUP and HOLD each spend (delay + 1) cycles, giving CSBEF + CSAFT + 2 of frame overhead.
    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            state      <= IDLE;
            SPI_CS_N   <= '1;
            CHAR_WDATA <= '0;
            RX_DATA    <= '0;
            FRAME_DONE <= 1'b0;
            CMD_ERR    <= 1'b0;
            remain     <= '0;
            dly        <= '0;
            csaft_q    <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            CMD_ERR    <= 1'b0;
            case (state)
                IDLE: if (cmd_acc) begin
                    remain  <= CMD_LEN;
                    dly     <= CSBEF;
                    csaft_q <= CSAFT;
                    if (CMD_LEN == '0) begin
                        CMD_ERR <= 1'b1;
                    end else begin
                        SPI_CS_N <= cs_sel;
                        state    <= SETUP;
                    end
                end
                SETUP: if (dly == '0) state <= FETCH;
                       else dly <= dly - 1'b1;
                FETCH: if (tx_acc) begin
                    CHAR_WDATA <= TX_DATA;
                    state      <= GO;
                end
                GO: state <= WAIT;
                WAIT: if (CHAR_DONE) begin
                    RX_DATA <= CHAR_RDATA;
                    remain  <= remain - 1'b1;
                    state   <= STORE;
                end
                STORE: if (store_done) begin
                    if (remain == '0) begin
                        dly   <= csaft_q;
                        state <= HOLD;
                    end else begin
                        state <= FETCH;
                    end
                end
                HOLD: if (dly == '0) begin
                    SPI_CS_N   <= '1;
                    FRAME_DONE <= 1'b1;
                    state      <= IDLE;
                end else begin
                    dly <= dly - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_espi_frame_ctrl.sv
// Directed bench for espi_frame_ctrl: table of frame commands plus hand-written reset sequence.
module tb_espi_frame_ctrl;
    logic        S_SYSCLK, S_RESET, S_ENABLE;
    logic        CMD_VALID, CMD_READY;
    logic [1:0]  CMD_CS;
    logic [15:0] CMD_LEN, CMD_SKIP;
    logic [3:0]  CSBEF, CSAFT;
    logic        TX_VALID, TX_READY;
    logic [31:0] TX_DATA;
    logic        RX_VALID, RX_READY;
    logic [31:0] RX_DATA;
    logic        CHAR_GO, CHAR_DONE;
    logic [31:0] CHAR_WDATA, CHAR_RDATA;
    logic [3:0]  SPI_CS_N;
    logic        BUSY, FRAME_DONE, CMD_ERR;

    espi_frame_ctrl #(.CHAR_NBITS(32), .NUM_CS(4), .LEN_W(16)) dut (
        .S_SYSCLK(S_SYSCLK), .S_RESET(S_RESET), .S_ENABLE(S_ENABLE),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_CS(CMD_CS),
        .CMD_LEN(CMD_LEN), .CMD_SKIP(CMD_SKIP), .CSBEF(CSBEF), .CSAFT(CSAFT),
        .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_DATA(TX_DATA),
        .RX_VALID(RX_VALID), .RX_READY(RX_READY), .RX_DATA(RX_DATA),
        .CHAR_GO(CHAR_GO), .CHAR_DONE(CHAR_DONE), .CHAR_WDATA(CHAR_WDATA),
        .CHAR_RDATA(CHAR_RDATA), .SPI_CS_N(SPI_CS_N), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE), .CMD_ERR(CMD_ERR)
    );

    initial begin
        S_SYSCLK = 1'b0;
        forever #5 S_SYSCLK = ~S_SYSCLK;
    end

    // Loopback transceiver: CHAR_DONE three cycles after GO, returning the sent character.
    initial begin
        int xdly;
        logic [31:0] xdat;
        xdly = 0; xdat = '0;
        CHAR_DONE = 1'b0; CHAR_RDATA = '0;
        forever begin
            @(negedge S_SYSCLK);
            if (CHAR_GO) begin xdly = 3; xdat = CHAR_WDATA; end
            @(posedge S_SYSCLK); #1;
            CHAR_DONE = 1'b0;
            if (S_RESET) xdly = 0;
            if (xdly > 0) begin
                xdly--;
                if (xdly == 0) begin CHAR_DONE = 1'b1; CHAR_RDATA = xdat; end
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    int go_cnt = 0, done_cnt = 0, err_cnt = 0, rx_cnt = 0, cs_low_cyc = 0, stab_viol = 0;
    int pre = 0, setup_meas = 0, hold_cnt = 0, hold_meas = 0;
    logic fgo = 1'b0, cs_prev = 1'b0, pv = 1'b0;
    logic [31:0] pd = '0;
    logic [3:0]  cs_frame = 4'hF;
    logic [31:0] rxbuf [0:255];

    always @(negedge S_SYSCLK) begin
        if (CHAR_GO) go_cnt++;
        if (FRAME_DONE) done_cnt++;
        if (CMD_ERR) err_cnt++;
        if (pv && (!RX_VALID || RX_DATA !== pd)) stab_viol++;
        pv = RX_VALID && !RX_READY;
        pd = RX_DATA;
        if (SPI_CS_N != 4'hF) begin
            if (!cs_prev) begin pre = 0; fgo = 1'b0; end
            if (CHAR_GO && !fgo) begin setup_meas = pre; fgo = 1'b1; end
            else if (!fgo) pre++;
            cs_low_cyc++;
            cs_frame = SPI_CS_N;
            hold_cnt = (RX_VALID && RX_READY) ? 0 : hold_cnt + 1;
            cs_prev = 1'b1;
        end else begin
            if (cs_prev) hold_meas = hold_cnt;
            cs_prev = 1'b0;
        end
        if (RX_VALID && RX_READY && rx_cnt < 256) begin
            rxbuf[rx_cnt] = RX_DATA;
            rx_cnt++;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] txv(input int i);
        return 32'h11 * 32'(i + 1);
    endfunction

    typedef struct {
        logic [1:0] cs;
        int len, skip, bef, aft, stall, bp;
        logic [3:0] exp_cs;
        int exp_go, exp_rx, exp_err, exp_done;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int go0, dn0, er0, rx0, csl0;
        go0 = go_cnt; dn0 = done_cnt; er0 = err_cnt; rx0 = rx_cnt; csl0 = cs_low_cyc;
        @(posedge S_SYSCLK); #1;
        CMD_VALID = 1'b1; CMD_CS = v.cs; CMD_LEN = 16'(v.len); CMD_SKIP = 16'(v.skip);
        CSBEF = 4'(v.bef); CSAFT = 4'(v.aft);
        RX_READY = (v.bp == 0);
        @(negedge S_SYSCLK);
        for (int t = 0; t < 100 && !CMD_READY; t++) @(negedge S_SYSCLK);
        chk("cmd_ready", 32'(CMD_READY), 32'd1);
        @(posedge S_SYSCLK); #1;
        CMD_VALID = 1'b0;
        if (v.len > 0) begin
            fork
                begin
                    for (int i = 0; i < v.len; i++) begin
                        if (i == 1 && v.stall > 0) begin
                            int g;
                            @(negedge S_SYSCLK);
                            for (int t = 0; t < 2000 && !TX_READY; t++) @(negedge S_SYSCLK);
                            g = go_cnt;
                            repeat (v.stall) @(negedge S_SYSCLK);
                            chk("stall_go", 32'(go_cnt), 32'(g));
                            chk("stall_cs", 32'(SPI_CS_N), 32'(v.exp_cs));
                        end
                        @(posedge S_SYSCLK); #1;
                        TX_VALID = 1'b1; TX_DATA = txv(i);
                        @(negedge S_SYSCLK);
                        for (int t = 0; t < 2000 && !TX_READY; t++) @(negedge S_SYSCLK);
                        chk("tx_ready", 32'(TX_READY), 32'd1);
                        @(posedge S_SYSCLK); #1;
                        TX_VALID = 1'b0;
                    end
                end
                begin
                    if (v.bp > 0) begin
                        int g2;
                        logic [31:0] d2;
                        @(negedge S_SYSCLK);
                        for (int t = 0; t < 2000 && !RX_VALID; t++) @(negedge S_SYSCLK);
                        chk("rx_valid", 32'(RX_VALID), 32'd1);
                        g2 = go_cnt; d2 = RX_DATA;
                        repeat (v.bp) @(negedge S_SYSCLK);
                        chk("bp_valid", 32'(RX_VALID), 32'd1);
                        chk("bp_data", RX_DATA, d2);
                        chk("bp_go", 32'(go_cnt), 32'(g2));
                        @(posedge S_SYSCLK); #1;
                        RX_READY = 1'b1;
                    end
                end
            join
            for (int t = 0; t < 200 && done_cnt == dn0; t++) @(negedge S_SYSCLK);
        end else begin
            repeat (5) @(negedge S_SYSCLK);
        end
        chk("go_count", 32'(go_cnt - go0), 32'(v.exp_go));
        chk("frame_done", 32'(done_cnt - dn0), 32'(v.exp_done));
        chk("cmd_err", 32'(err_cnt - er0), 32'(v.exp_err));
        chk("rx_count", 32'(rx_cnt - rx0), 32'(v.exp_rx));
        if (v.len == 0) begin
            chk("cs_idle", 32'(cs_low_cyc - csl0), 32'd0);
        end else begin
            chk("cs_sel", 32'(cs_frame), 32'(v.exp_cs));
            chk("setup_cyc", 32'(setup_meas), 32'(v.bef + 2));
            chk("hold_cyc", 32'(hold_meas), 32'(v.aft + 1));
            chk("cs_end", 32'(SPI_CS_N), 32'hF);
        end
        for (int k = 0; k < v.exp_rx; k++)
            chk("rx_data", rxbuf[rx0 + k], txv(v.len - v.exp_rx + k));
    endtask

    initial begin
        vec_t vecs [6];
        int g0, d0;
        vecs[0] = '{2'd1, 3, 0, 2, 3, 0, 0, 4'b1101, 3, 3, 0, 1};
        vecs[1] = '{2'd0, 0, 0, 1, 1, 0, 0, 4'b1111, 0, 0, 1, 0};
        vecs[2] = '{2'd2, 3, 0, 0, 0, 20, 0, 4'b1011, 3, 3, 0, 1};
        vecs[3] = '{2'd3, 2, 0, 1, 1, 0, 10, 4'b0111, 2, 2, 0, 1};
`ifdef ESPI_RX_SKIP_EN
        vecs[4] = '{2'd0, 4, 2, 0, 2, 0, 0, 4'b1110, 4, 2, 0, 1};
`else
        vecs[4] = '{2'd0, 4, 2, 0, 2, 0, 0, 4'b1110, 4, 4, 0, 1};
`endif
        vecs[5] = '{2'd1, 1, 0, 15, 15, 0, 0, 4'b1101, 1, 1, 0, 1};

        S_RESET = 1'b1; S_ENABLE = 1'b1; CMD_VALID = 1'b0; CMD_CS = '0;
        CMD_LEN = '0; CMD_SKIP = '0; CSBEF = '0; CSAFT = '0;
        TX_VALID = 1'b0; TX_DATA = '0; RX_READY = 1'b1;
        repeat (3) @(posedge S_SYSCLK); #1;
        chk("rst_cs", 32'(SPI_CS_N), 32'hF);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_outs", 32'({CHAR_GO, TX_READY, RX_VALID, FRAME_DONE, CMD_ERR}), 32'd0);
        chk("rst_data", CHAR_WDATA | RX_DATA, 32'd0);
        S_RESET = 1'b0;
        @(posedge S_SYSCLK); #1;
        S_ENABLE = 1'b0; #1;
        chk("ready_dis", 32'(CMD_READY), 32'd0);
        S_ENABLE = 1'b1; #1;
        chk("ready_en", 32'(CMD_READY), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while character 2 is in flight.
        g0 = go_cnt; d0 = done_cnt;
        @(posedge S_SYSCLK); #1;
        CMD_VALID = 1'b1; CMD_CS = 2'd2; CMD_LEN = 16'd3; CMD_SKIP = '0; CSBEF = '0; CSAFT = '0;
        TX_VALID = 1'b1; TX_DATA = 32'hAA; RX_READY = 1'b1;
        @(posedge S_SYSCLK); #1;
        CMD_VALID = 1'b0;
        @(negedge S_SYSCLK);
        for (int t = 0; t < 500 && go_cnt < g0 + 2; t++) @(negedge S_SYSCLK);
        chk("rst_go2", 32'(go_cnt - g0), 32'd2);
        @(posedge S_SYSCLK); #1;
        S_RESET = 1'b1; #1;
        chk("midrst_cs", 32'(SPI_CS_N), 32'hF);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        @(posedge S_SYSCLK); #1;
        S_RESET = 1'b0; TX_VALID = 1'b0;
        repeat (8) @(negedge S_SYSCLK);
        chk("midrst_nodone", 32'(done_cnt - d0), 32'd0);
        run_vec(vecs[0]);

        chk("rx_stable", 32'(stab_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
